// File: rtl/riscv_mem_pkg.sv
// Shared types and limits for the riscv data memory block.
// Holds the request FSM state encoding, the latency bound and the width of
// the wait counter, plus a power-of-two helper used by parameter checks.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int MAX_LATENCY = 15;
  // Wide enough to hold MAX_LATENCY-1.
  localparam int CNT_W       = 4;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/riscv_mem_array.sv
// Single-port synchronous word array with per-byte write enables.
// Ports: en_i/we_i select a read or write of word addr_i on the rising edge;
// be_i masks write lanes; rdata_o holds the last word read (registered).
module riscv_mem_array #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = "",
  localparam int NB       = DATA_W / 8,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [NB-1:0]     be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_data_mem.sv
// Data memory with valid/ready request side and a one-cycle response strobe.
// Ports: clk/reset (sync, active-low); req_* request with byte enables;
// rsp_valid/rsp_rdata/rsp_err response, LATENCY+1 cycles after accept.
module riscv_data_mem
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  if (!is_pow2(DATA_W) || DATA_W < 8) begin : g_bad_data_w
    $error("riscv_data_mem: DATA_W must be a power of two and at least 8");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("riscv_data_mem: DEPTH must be a power of two");
  end
  if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("riscv_data_mem: LATENCY must be in 0..15");
  end

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              err_q;
  logic              wr_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;

  // Address decode of the incoming request.
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              err_d;
  logic              accept;

  assign word_idx     = req_addr >> OFF;
  assign misaligned   = |(req_addr & ADDR_W'(NB - 1));
  assign out_of_range = word_idx >= ADDR_W'(DEPTH);
  assign err_d        = misaligned | out_of_range;
  // ready_q is only ever high in IDLE, so accept implies IDLE.
  assign accept       = req_valid & ready_q;

  // The array access happens on the edge that enters RESP. With zero latency
  // that is the accept edge itself, so the array is fed straight from the
  // request inputs; otherwise it is fed from the captured registers.
  logic              direct;
  logic              wait_done;
  logic              arr_en;
  logic              arr_we;
  logic [AW-1:0]     arr_addr;
  logic [NB-1:0]     arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign direct    = accept && (LATENCY == 0);
  assign wait_done = (state_q == WAIT) && (cnt_q == '0);
  // Gating with reset keeps a discarded request from committing its write.
  assign arr_en    = reset & ((direct & ~err_d) | (wait_done & ~err_q));
  assign arr_we    = direct ? req_write          : wr_q;
  assign arr_addr  = direct ? word_idx[AW-1:0]   : idx_q;
  assign arr_be    = direct ? req_be             : be_q;
  assign arr_wdata = direct ? req_wdata          : wdata_q;

  riscv_mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .be_i    (arr_be),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            err_q   <= err_d;
            wr_q    <= req_write;
            idx_q   <= word_idx[AW-1:0];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_M1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & err_q;
  // Read data only for successful reads; zero on writes, errors and idle.
  assign rsp_rdata = (rsp_valid_q & ~err_q & ~wr_q) ? arr_rdata : '0;

endmodule
